spi_master_cmd: RTL



---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_sclk_gen.sv | 41 ++++
 rtl/spi_master_cmd.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI command master and its SCLK generator.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT_TX,
    ST_SHIFT_RX,
    ST_CS_HOLD,
    ST_CS_GAP
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

  // Width of a counter able to hold every value from 0 up to data_w inclusive.
  function automatic int rx_len_w(input int data_w);
    return (data_w < 1) ? 1 : $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles a registered sclk every CLK_DIV cycles while run is high
// and flags whether each toggle is the leading or the trailing edge of a bit.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2,
  parameter bit CPOL    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic sclk,
  output logic lead_stb,
  output logic trail_stb
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             half_done;

  // Strobes coincide with the clock edge on which sclk itself toggles.
  assign half_done = run && (cnt == CNT_MAX);
  assign lead_stb  = half_done && (sclk == CPOL);
  assign trail_stb = half_done && (sclk != CPOL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      sclk <= CPOL;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= CPOL;
    end else if (half_done) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_cmd.sv
// SPI command master: sends one instruction MSB first, then reads a runtime
// selected number of response bits, with a start/busy/done handshake.
module spi_master_cmd #(
  parameter int INST_W  = 8,
  parameter int DATA_W  = 24,
  parameter int CLK_DIV = 2,
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic [INST_W-1:0]                      inst,
  input  logic [spi_pkg::rx_len_w(DATA_W)-1:0]   rx_len,
  output logic                                   busy,
  output logic                                   done,
  output logic [DATA_W-1:0]                      rx_data,
  output logic                                   spi_sclk,
  output logic                                   spi_mosi,
  input  logic                                   spi_miso,
  output logic                                   spi_cs_n
);

  import spi_pkg::*;

  localparam int LEN_W   = rx_len_w(DATA_W);
  localparam int BIT_MAX = (INST_W > DATA_W) ? INST_W : DATA_W;
  localparam int BIT_W   = $clog2(BIT_MAX + 1);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam spi_mode_t MODE        = '{cpol: CPOL, cpha: CPHA};
  localparam bit        SAMPLE_LEAD = (MODE == MODE0) || (MODE == MODE2);

  state_t            state;
  logic [INST_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_clamped;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DIV_W-1:0]  phase_cnt;
  logic              run;
  logic              lead_stb;
  logic              trail_stb;
  logic              sample_stb;
  logic              change_stb;

  assign len_clamped = (rx_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : rx_len;
  assign run         = (state == ST_SHIFT_TX) || (state == ST_SHIFT_RX);
  assign sample_stb  = SAMPLE_LEAD ? lead_stb : trail_stb;
  assign change_stb  = SAMPLE_LEAD ? trail_stb : lead_stb;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_sclk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .sclk      (spi_sclk),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb)
  );

  // The TX register always holds the next bit to present in its MSB; for
  // CPHA=0 the first bit goes straight onto MOSI at accept, so it is pre-shifted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      len_q     <= '0;
      bit_cnt   <= '0;
      phase_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            tx_sr     <= CPHA ? inst : (inst << 1);
            spi_mosi  <= CPHA ? 1'b0 : inst[INST_W-1];
            len_q     <= len_clamped;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            spi_cs_n  <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_CS_SETUP;
          end
        end

        ST_CS_SETUP: begin
          if (phase_cnt == DIV_MAX) begin
            phase_cnt <= '0;
            state     <= ST_SHIFT_TX;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        ST_SHIFT_TX: begin
          if (change_stb) begin
            spi_mosi <= tx_sr[INST_W-1];
            tx_sr    <= tx_sr << 1;
          end
          if (trail_stb) begin
            if (bit_cnt == BIT_W'(INST_W - 1)) begin
              bit_cnt <= '0;
              state   <= (len_q == '0) ? ST_CS_HOLD : ST_SHIFT_RX;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_SHIFT_RX: begin
          if (change_stb) begin
            spi_mosi <= 1'b0;
          end
          if (sample_stb) begin
            rx_sr <= (rx_sr << 1) | DATA_W'(spi_miso);
          end
          if (trail_stb) begin
            if (bit_cnt == BIT_W'(len_q) - 1'b1) begin
              bit_cnt <= '0;
              state   <= ST_CS_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_CS_HOLD: begin
          if (phase_cnt == DIV_MAX) begin
            phase_cnt <= '0;
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            done      <= 1'b1;
            rx_data   <= rx_sr;
            state     <= ST_CS_GAP;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        ST_CS_GAP: begin
          if (phase_cnt == DIV_MAX) begin
            phase_cnt <= '0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
